// File: rtl/flash_model.sv
// Behavioural NOR-flash model: word read, NOR program (AND) and sector erase with
// cycle-accurate latency. Define FLASH_MODEL_ERR_EN to build the sticky program-error flag.
module flash_model #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 24,
  parameter int DEPTH        = 256,
  parameter int SECTOR_WORDS = 16,
  parameter int RD_LAT       = 2,
  parameter int PROG_CYC     = 8,
  parameter int ERASE_CYC    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              we_n,
  input  logic              oe_n,
  input  logic              erase_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SEC_W = $clog2(SECTOR_WORDS);
  localparam int MAXL  = (RD_LAT > PROG_CYC) ? ((RD_LAT > ERASE_CYC) ? RD_LAT : ERASE_CYC)
                                             : ((PROG_CYC > ERASE_CYC) ? PROG_CYC : ERASE_CYC);
  localparam int CNT_W = $clog2(MAXL + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_PROG  = 2'd2;
  localparam logic [1:0] S_ERASE = 2'd3;

  // Array powers up erased; reset deliberately leaves it alone.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '1};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q;

  logic              accept, done;
  logic [1:0]        cmd, op_st;
  logic [CNT_W-1:0]  cmd_rem;
  logic [IDX_W-1:0]  op_idx;
  logic [DATA_W-1:0] op_wd;
  logic              unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:IDX_W];

  always_comb begin
    accept  = (state_q == S_IDLE) && !cs_n && (!erase_n || !we_n || !oe_n);
    cmd     = !erase_n ? S_ERASE : (!we_n ? S_PROG : S_READ);
    cmd_rem = CNT_W'(RD_LAT - 1);
    if (cmd == S_PROG)  cmd_rem = CNT_W'(PROG_CYC - 1);
    if (cmd == S_ERASE) cmd_rem = CNT_W'(ERASE_CYC - 1);

    // Completion either ends a running op or, for single-cycle ops, happens on the accept edge.
    done   = 1'b0;
    op_st  = state_q;
    op_idx = idx_q;
    op_wd  = wd_q;
    if (state_q != S_IDLE && cnt_q == '0) begin
      done = 1'b1;
    end else if (accept && cmd_rem == '0) begin
      done   = 1'b1;
      op_st  = cmd;
      op_idx = addr[IDX_W-1:0];
      op_wd  = wdata;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    rdata_d = (done && op_st == S_READ) ? mem_q[op_idx] : rdata_q;
    if (state_q != S_IDLE) begin
      if (cnt_q == '0) state_d = S_IDLE;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (accept && cmd_rem != '0) begin
      state_d = cmd;
      cnt_d   = cmd_rem - 1'b1;
      idx_d   = addr[IDX_W-1:0];
      wd_d    = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      ready_q <= done;
    end
  end

  always_ff @(posedge clk) begin
    if (done && op_st == S_PROG) begin
      mem_q[op_idx] <= mem_q[op_idx] & op_wd;
    end else if (done && op_st == S_ERASE) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((IDX_W'(i) >> SEC_W) == (op_idx >> SEC_W)) mem_q[i] <= '1;
      end
    end
  end

`ifdef FLASH_MODEL_ERR_EN
  logic err_q, err_d;

  // A program that tries to raise a cleared bit is flagged; the array still takes the AND.
  always_comb begin
    err_d = err_q;
    if (done && op_st == S_PROG && |(op_wd & ~mem_q[op_idx])) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = (state_q != S_IDLE);
endmodule

// File: doc/flash_model.md
# flash_model

Parametrised behavioural NOR-flash model with configurable geometry and timing. It provides word read, program and sector erase operations, each with cycle-accurate latency and a busy/ready handshake. It replaces the fixed 16-word flash stub wherever the boot and fetch logic must be exercised against realistic flash timing and NOR bit semantics.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits.
- `ADDR_W`, 24, address width in bits.
- `DEPTH`, 256, number of words; must be a power of two and ≤ 2^ADDR_W.
- `SECTOR_WORDS`, 16, words per erase sector; must be a power of two and must divide `DEPTH`.
- `RD_LAT`, 2, read latency in cycles; must be ≥ 1.
- `PROG_CYC`, 8, program duration in cycles; must be ≥ 1.
- `ERASE_CYC`, 32, sector erase duration in cycles; must be ≥ 1.

Ports:
- `clk` input 1: the single clock; rising edge active.
- `rst` input 1: asynchronous reset, active-high.
- `cs_n` input 1: chip select, active-low.
- `we_n` input 1: program request, active-low.
- `oe_n` input 1: read request, active-low.
- `erase_n` input 1: sector erase request, active-low.
- `addr` input `ADDR_W`: word address.
- `wdata` input `DATA_W`: program data.
- `rdata` output `DATA_W`: read data.
- `ready` output 1: one-cycle pulse when an operation completes.
- `busy` output 1: high while an operation is in progress.
- `err` output 1: sticky program-error flag (see Configuration).

## Operation
- State machine states: IDLE, READ, PROG, ERASE.
- Command acceptance:
  - A command is accepted at a rising edge only when the state is IDLE and `cs_n` = 0.
  - Priority is `erase_n` > `we_n` > `oe_n`. If none of the three is low, nothing is accepted.
  - `addr` and `wdata` are captured at the accept edge. Later changes have no effect on the operation.
- Word index is `addr[log2(DEPTH)-1:0]`. Higher address bits are ignored, so accesses wrap.
- Read: returns `mem[index]` on `rdata`.
- Program uses NOR semantics: `mem[index] <= mem[index] & wdata`. Program never sets a bit.
- Erase: every word in the sector containing `index` is set to all ones. The sector base is `index` with its low log2(`SECTOR_WORDS`) bits cleared.
- Memory contents:
  - The array initialises to all ones at time zero.
  - Reset does not alter the array.
- Program and erase write the array only at their completion edge.
- Commands presented while not IDLE are ignored. No queueing.
- Reset mid-operation aborts the operation. An aborted program or erase leaves the array unchanged.
- `rdata` holds the last completed read value until the next read completes.

## Timing
- Reset values: state IDLE, `rdata` = 0, `ready` = 0, `busy` = 0, `err` = 0.
- Let E0 be the accept edge. The completion edge is E0 + L − 1, where L is `RD_LAT`, `PROG_CYC` or `ERASE_CYC` for the operation.
- `busy` is high after E0 and low after the completion edge. When L = 1, `busy` never goes high.
- After the completion edge:
  - `ready` = 1 for exactly one cycle.
  - The state is IDLE.
  - For a read, `rdata` is valid.
- A new command may be presented during the `ready` cycle and is accepted at the following edge. This gives back-to-back throughput of one operation per L cycles.
- `RD_LAT` = 1 reproduces single-cycle stub behaviour: `rdata` and `ready` are valid in the cycle after the request.

## Configuration
- `FLASH_MODEL_ERR_EN` defined:
  - At the completion of a program, if `wdata` has a 1 where the stored word has a 0, `err` is set.
  - `err` stays set until `rst`.
  - The array update is still `mem & wdata`.
- `FLASH_MODEL_ERR_EN` undefined: `err` is tied to 0, and no detection logic is built.

## Test plan
- Reset then read, default parameters: `cs_n` = 0, `oe_n` = 0, `addr` = 5 at E0 → `busy` = 1 after E0; `ready` = 1 and `rdata` = 0xFFFFFFFF after E0+1; `busy` = 0.
- Program 0x12345678 to `addr` 3, then read `addr` 3 → `busy` high for 7 cycles; `ready` after E0+7; read returns 0x12345678.
- NOR semantics and error flag: program `addr` 3 with 0xFFFF0000 over 0x12345678 → read returns 0x12340000. With `FLASH_MODEL_ERR_EN` defined, `err` = 1; without it, `err` = 0.
- Sector erase at `addr` 0x13 → after 32 cycles, words 0x10–0x1F read 0xFFFFFFFF and word 0x0F is unchanged. A read request held during the erase is ignored until `ready`.
- Priority and wrap: assert `erase_n`, `we_n` and `oe_n` together at `addr` 0x103 → erase of sector 0 only (wrap to `index` 3), no `rdata` change, `ready` after 32 cycles.
- Reset mid-program: assert `rst` 4 cycles into a program of 0x0 to `addr` 7 → `busy` and `ready` are 0 immediately, and `addr` 7 still reads 0xFFFFFFFF.
